// File: rtl/ir_ac_dc_extractor_if.sv
// Sample-in / result-out bundle between the IR FIR stage, the AC/DC extractor and the SpO2 ratio stage.
`default_nettype none

interface ir_ac_dc_extractor_if #(
  parameter int DW = 20
);
  logic          sample_valid;
  logic [DW-1:0] ir_filtered;
  logic          restart;
  logic          result_ready;
  logic          result_valid;
  logic [DW-1:0] ac_out;
  logic [DW-1:0] dc_out;
  logic          overrun;

  modport slave (
    input  sample_valid, ir_filtered, restart, result_ready,
    output result_valid, ac_out, dc_out, overrun
  );

  modport master (
    output sample_valid, ir_filtered, restart, result_ready,
    input  result_valid, ac_out, dc_out, overrun
  );
endinterface

`default_nettype wire

// File: rtl/ir_ac_dc_extractor.sv
// Splits each WIN_LEN-sample window of filtered IR into AC (max-min) and DC (mean) after a settle period.
`default_nettype none

module ir_ac_dc_extractor #(
  parameter int DW             = 20,
  parameter int LOG2_WIN       = 8,
  parameter int WIN_LEN        = 256,
  parameter int SETTLE_SAMPLES = 22
) (
  input  logic                  CLK_Filter,
  input  logic                  rst_n,
  ir_ac_dc_extractor_if.slave   bus
);

  localparam int SUMW = DW + LOG2_WIN;
  localparam int SW   = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SW-1:0]       SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [LOG2_WIN-1:0] WIN_LAST    = LOG2_WIN'(WIN_LEN - 1);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    ACCUM  = 1'b1
  } state_t;

  // With no settle period both reset and restart land straight in ACCUM.
  localparam state_t ENTRY_STATE = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;

  state_t              state, state_nxt;
  logic [SW-1:0]       settle_cnt;
  logic [LOG2_WIN-1:0] win_idx;
  logic [DW-1:0]       max_q, min_q;
  logic [SUMW-1:0]     sum_q;
  logic                valid_q, overrun_q;
  logic [DW-1:0]       ac_q, dc_q;

  logic                accum_step, settle_step, win_load;
  logic [DW-1:0]       max_nxt, min_nxt;
  logic [SUMW-1:0]     sum_nxt;

  always_comb begin
    state_nxt   = state;
    settle_step = 1'b0;
    accum_step  = 1'b0;
    if (bus.restart) begin
      state_nxt = ENTRY_STATE;
    end else if (bus.sample_valid) begin
      case (state)
        SETTLE: begin
          settle_step = 1'b1;
          if (settle_cnt == SETTLE_LAST) state_nxt = ACCUM;
        end
        ACCUM: accum_step = 1'b1;
        default: state_nxt = ENTRY_STATE;
      endcase
    end
  end

  always_comb begin
    max_nxt = max_q;
    min_nxt = min_q;
    sum_nxt = sum_q + SUMW'(bus.ir_filtered);
    if (win_idx == '0) begin
      max_nxt = bus.ir_filtered;
      min_nxt = bus.ir_filtered;
      sum_nxt = SUMW'(bus.ir_filtered);
    end else begin
      if (bus.ir_filtered > max_q) max_nxt = bus.ir_filtered;
      if (bus.ir_filtered < min_q) min_nxt = bus.ir_filtered;
    end
  end

  assign win_load = accum_step && (win_idx == WIN_LAST);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTRY_STATE;
      settle_cnt <= '0;
      win_idx    <= '0;
      max_q      <= '0;
      min_q      <= '0;
      sum_q      <= '0;
    end else begin
      state <= state_nxt;
      if (bus.restart) begin
        settle_cnt <= '0;
        win_idx    <= '0;
      end else if (settle_step) begin
        settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;
      end else if (accum_step) begin
        win_idx <= win_idx + 1'b1;
        max_q   <= max_nxt;
        min_q   <= min_nxt;
        sum_q   <= sum_nxt;
      end
    end
  end

  // A new result always wins; it is only an overrun if the old one was not taken on this edge.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ac_q      <= '0;
      dc_q      <= '0;
    end else if (win_load) begin
      valid_q <= 1'b1;
      ac_q    <= max_nxt - min_nxt;
      dc_q    <= sum_nxt[SUMW-1:LOG2_WIN];
      if (valid_q && !bus.result_ready) overrun_q <= 1'b1;
    end else if (valid_q && bus.result_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.ac_out       = ac_q;
  assign bus.dc_out       = dc_q;
  assign bus.overrun      = overrun_q;

endmodule

`default_nettype wire
